macload_fetch: RTL

Load-issue stage that sits directly downstream of the ID stage and directly upstream of `macload_controller`. It accepts MAC-load commands for the activation (A) or weight (W) buffer and fetches one 32-bit word from data memory over an OBI-style request/grant/rvalid port. The word is written into the NN operand register file. Each granted request emits a one-cycle `update_a_o`/`update_w_o` pulse, which `macload_controller` uses to advance the CSR-held pointer by stride or rollback.

---
 rtl/macload_fetch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/macload_fetch.sv
// Load-issue stage between ID and macload_controller: fetches one word per MAC-load
// command over an OBI-style port and writes it into the A or W NN operand bank.
module macload_fetch #(
    parameter int FIFO_DEPTH    = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        load_a_i,
    input  logic        load_w_i,
    input  logic [1:0]  load_idx_i,
    output logic        ready_o,
    input  logic [31:0] a_address_i,
    input  logic [31:0] w_address_i,
    output logic        update_a_o,
    output logic        update_w_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        nn_we_o,
    output logic        nn_bank_o,
    output logic [1:0]  nn_waddr_o,
    output logic [31:0] nn_wdata_o
);

    // Handshakes: ID command is taken when exactly one load input is high and
    // ready_o is 1; a memory request is taken when data_req_o && data_gnt_i.
    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic        bank_q;
    logic [1:0]  idx_q;
    logic [31:0] addr_q;
    logic [2:0]  tag_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic [7:0]  settle_q;
    logic        update_a_q, update_w_q;
    logic        nn_we_q, nn_bank_q;
    logic [1:0]  nn_waddr_q;
    logic [31:0] nn_wdata_q;
    logic        ready, accept, grant, pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign ready  = (state_q == IDLE) && (settle_q == 8'd0) && (count_q < 3'(FIFO_DEPTH));
    assign accept = ready && (load_a_i ^ load_w_i);
    assign grant  = (state_q == REQ) && data_gnt_i;
    assign pop    = data_rvalid_i && (count_q != 3'd0);

    // Gated with reset so the stage looks fully quiet while held in reset.
    assign ready_o     = ready && rstn_i;
    assign data_addr_o = addr_q;
    assign update_a_o  = update_a_q;
    assign update_w_o  = update_w_q;
    assign nn_we_o     = nn_we_q;
    assign nn_bank_o   = nn_bank_q;
    assign nn_waddr_o  = nn_waddr_q;
    assign nn_wdata_o  = nn_wdata_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = REQ;
            end
            REQ: begin
                data_req_o = 1'b1;
                if (data_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bank_q     <= 1'b0;
            idx_q      <= 2'd0;
            addr_q     <= 32'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            settle_q   <= 8'd0;
            update_a_q <= 1'b0;
            update_w_q <= 1'b0;
            nn_we_q    <= 1'b0;
            nn_bank_q  <= 1'b0;
            nn_waddr_q <= 2'd0;
            nn_wdata_q <= 32'd0;
            for (int i = 0; i < 4; i++) tag_q[i] <= 3'd0;
        end else begin
            if (accept) begin
                bank_q <= load_w_i;
                idx_q  <= load_idx_i;
                addr_q <= (load_w_i ? w_address_i : a_address_i) & 32'hFFFF_FFFC;
            end

            update_a_q <= grant && !bank_q;
            update_w_q <= grant && bank_q;

            // Settle window lets the CSR pointer update reach a/w_address_i.
            if (grant) begin
                settle_q <= 8'(SETTLE_CYCLES);
            end else if (settle_q != 8'd0) begin
                settle_q <= settle_q - 8'd1;
            end

            if (grant) begin
                tag_q[wr_ptr_q] <= {bank_q, idx_q};
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end

            nn_we_q <= pop;
            if (pop) begin
                {nn_bank_q, nn_waddr_q} <= tag_q[rd_ptr_q];
                nn_wdata_q              <= data_rdata_i;
                rd_ptr_q                <= next_ptr(rd_ptr_q);
            end

            case ({grant, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
